p2s_burst_dbuf: RTL and testbench

- Parameterised successor to the fixed-count parallel-to-serial write-data serializer that feeds the DDR controller write-data path (app_wdf_*).
- Accepts a wide parallel word with a per-transfer beat count (1..MAX_SEQ_CNT) through a valid/ready handshake.
- Buffers up to two words in ping-pong slots, so back-to-back bursts stream with no idle beat.
- Emits APP_DATA_WIDTH beats with an AXI-style valid that never depends combinationally on app_wdf_rdy.

---
 rtl/p2s_burst_dbuf.sv | 138 +++++++++++++
 tb/tb_p2s_burst_dbuf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/p2s_burst_dbuf.sv
// p2s_burst_dbuf: parallel-to-serial write-data serializer for the DDR
// app_wdf_* path. Each accepted parallel word carries its own beat count.
// Two ping-pong slots let a second word wait while the first drains, so
// consecutive bursts stream with no idle beat. Every output is driven from
// registered state only; none of them depends combinationally on app_wdf_rdy.
module p2s_burst_dbuf #(
    parameter int MAX_SEQ_CNT    = 8,
    parameter int APP_DATA_WIDTH = 64,
    parameter int LEN_W          = $clog2(MAX_SEQ_CNT + 1),
    parameter int BCNT_W         = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  par_valid,
    output logic                                  par_ready,
    input  logic [APP_DATA_WIDTH*MAX_SEQ_CNT-1:0] par,
    input  logic [LEN_W-1:0]                      par_len,
    input  logic                                  app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0]             seq,
    output logic                                  seq_valid,
    output logic                                  seq_last,
    output logic                                  busy,
    output logic                                  err_len,
    output logic [BCNT_W-1:0]                     burst_cnt
);

    localparam int BEAT_W = $clog2(MAX_SEQ_CNT);
    localparam int PAR_W  = APP_DATA_WIDTH * MAX_SEQ_CNT;

    // Ping-pong slot storage; data needs no reset because occupancy gates it.
    logic [PAR_W-1:0]  slot_par_q [2];
    logic [LEN_W-1:0]  slot_len_q [2];

    logic              wr_ptr_q,    wr_ptr_d;
    logic              rd_ptr_q,    rd_ptr_d;
    logic [1:0]        occ_q,       occ_d;
    logic [BEAT_W-1:0] beat_q,      beat_d;
    logic              par_ready_q, par_ready_d;
    logic              err_len_q,   err_len_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic                      have_word;
    logic                      is_last;
    logic [LEN_W-1:0]          cur_len;
    logic                      beat_xfer;
    logic                      pop_word;
    logic                      push_hs;
    logic                      len_ok;
    logic                      store_word;
    logic [APP_DATA_WIDTH-1:0] beat_data [MAX_SEQ_CNT];

    // Slice the word in the read slot into individual beats.
    generate
        for (genvar gi = 0; gi < MAX_SEQ_CNT; gi++) begin : g_beats
            assign beat_data[gi] = slot_par_q[rd_ptr_q][gi*APP_DATA_WIDTH +: APP_DATA_WIDTH];
        end
    endgenerate

    assign have_word  = (occ_q != 2'd0);
    assign cur_len    = slot_len_q[rd_ptr_q];
    assign is_last    = have_word && (LEN_W'(beat_q) == (cur_len - LEN_W'(1)));
    assign beat_xfer  = have_word && app_wdf_rdy;
    assign pop_word   = beat_xfer && is_last;
    assign push_hs    = par_valid && par_ready_q;
    assign len_ok     = (par_len != '0) && (par_len <= LEN_W'(MAX_SEQ_CNT));
    assign store_word = push_hs && len_ok;

    assign seq       = have_word ? beat_data[beat_q] : '0;
    assign seq_valid = have_word;
    assign seq_last  = is_last;
    assign busy      = have_word;
    assign par_ready = par_ready_q;
    assign err_len   = err_len_q;
    assign burst_cnt = burst_cnt_q;

    // Next-state: beat stepping, pointer toggles, occupancy and sticky error.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        beat_d      = beat_q;
        burst_cnt_d = burst_cnt_q;
        err_len_d   = err_len_q | (push_hs & ~len_ok);

        if (beat_xfer) begin
            if (is_last) begin
                beat_d      = '0;
                rd_ptr_d    = ~rd_ptr_q;
                burst_cnt_d = burst_cnt_q + BCNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        if (store_word) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        case ({store_word, pop_word})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Registered ready: a pop while full only opens the gate next cycle.
        par_ready_d = (occ_d < 2'd2);
    end

    // Control state register; reset drops any buffered words on the spot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            beat_q      <= '0;
            par_ready_q <= 1'b0;
            err_len_q   <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            beat_q      <= beat_d;
            par_ready_q <= par_ready_d;
            err_len_q   <= err_len_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Capture a legal word into the slot selected by the write pointer.
    always_ff @(posedge clk) begin
        if (store_word) begin
            slot_par_q[wr_ptr_q] <= par;
            slot_len_q[wr_ptr_q] <= par_len;
        end
    end

endmodule

// File: tb/tb_p2s_burst_dbuf.sv
// Bench for p2s_burst_dbuf: a table of per-cycle vectors with hand-computed
// expectations, plus a streamed sequence that wraps the burst counter.
module tb_p2s_burst_dbuf;

    localparam int MAX    = 8;
    localparam int W      = 64;
    localparam int LEN_W  = 4;
    localparam int BCNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 par_valid;
    logic                 par_ready;
    logic [W*MAX-1:0]     par;
    logic [LEN_W-1:0]     par_len;
    logic                 app_wdf_rdy;
    logic [W-1:0]         seq;
    logic                 seq_valid;
    logic                 seq_last;
    logic                 busy;
    logic                 err_len;
    logic [BCNT_W-1:0]    burst_cnt;

    always #5 clk = ~clk;

    p2s_burst_dbuf #(
        .MAX_SEQ_CNT   (MAX),
        .APP_DATA_WIDTH(W),
        .BCNT_W        (BCNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .par        (par),
        .par_len    (par_len),
        .app_wdf_rdy(app_wdf_rdy),
        .seq        (seq),
        .seq_valid  (seq_valid),
        .seq_last   (seq_last),
        .busy       (busy),
        .err_len    (err_len),
        .burst_cnt  (burst_cnt)
    );

    typedef struct {
        bit rst_n;
        bit pv;
        int tag;
        int len;
        bit rdy;
        bit pr;
        bit sv;
        int etag;
        int ek;
        bit sl;
        bit busy;
        bit err;
        int bcnt;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    // Beat k of word 'tag': tag in the top byte, 0x11*(k+1) in the low byte.
    function automatic logic [W-1:0] bv(input int tag, input int k);
        return {8'(tag), 48'h0, 8'((k + 1) * 17)};
    endfunction

    function automatic logic [W*MAX-1:0] mk_par(input int tag);
        logic [W*MAX-1:0] p;
        p = '0;
        for (int k = 0; k < MAX; k++) p[k*W +: W] = bv(tag, k);
        return p;
    endfunction

    task automatic add(input bit r, input bit pv, input int tag, input int len, input bit rdy,
                       input bit pr, input bit sv, input int etag, input int ek, input bit sl,
                       input bit bsy, input bit er, input int bc);
        vec_t v;
        v.rst_n = r;  v.pv = pv;  v.tag = tag;  v.len = len;  v.rdy = rdy;
        v.pr = pr;    v.sv = sv;  v.etag = etag; v.ek = ek;   v.sl = sl;
        v.busy = bsy; v.err = er; v.bcnt = bc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        par_valid   = 1'b0;
        par         = '0;
        par_len     = '0;
        app_wdf_rdy = 1'b1;

        // Single len-4 burst, constant ready
        add(1,0,0,0,1, 0,0,0,0,0,0,0,0);
        add(1,1,0,4,1, 1,0,0,0,0,0,0,0);
        add(1,0,0,0,1, 1,1,0,0,0,1,0,0);
        add(1,0,0,0,1, 1,1,0,1,0,1,0,0);
        add(1,0,0,0,1, 1,1,0,2,0,1,0,0);
        add(1,0,0,0,1, 1,1,0,3,1,1,0,0);
        add(1,0,0,0,1, 1,0,0,0,0,0,0,1);
        // Back-to-back len 3 then len 8: 11 contiguous beats
        add(1,1,1,3,1, 1,0,0,0,0,0,0,1);
        add(1,1,2,8,1, 1,1,1,0,0,1,0,1);
        add(1,0,0,0,1, 0,1,1,1,0,1,0,1);
        add(1,0,0,0,1, 0,1,1,2,1,1,0,1);
        for (int k = 0; k < 8; k++) add(1,0,0,0,1, 1,1,2,k,(k == 7),1,0,2);
        add(1,0,0,0,1, 1,0,0,0,0,0,0,3);
        // Ready toggling 1,0,0,1,0,1,1 during a len-4 burst
        add(1,1,3,4,1, 1,0,0,0,0,0,0,3);
        add(1,0,0,0,1, 1,1,3,0,0,1,0,3);
        add(1,0,0,0,0, 1,1,3,1,0,1,0,3);
        add(1,0,0,0,0, 1,1,3,1,0,1,0,3);
        add(1,0,0,0,1, 1,1,3,1,0,1,0,3);
        add(1,0,0,0,0, 1,1,3,2,0,1,0,3);
        add(1,0,0,0,1, 1,1,3,2,0,1,0,3);
        add(1,0,0,0,1, 1,1,3,3,1,1,0,3);
        add(1,0,0,0,1, 1,0,0,0,0,0,0,4);
        // Illegal lengths 0 and 9, then a legal len-2 word
        add(1,1,4,0,1, 1,0,0,0,0,0,0,4);
        add(1,1,4,9,1, 1,0,0,0,0,0,1,4);
        add(1,1,5,2,1, 1,0,0,0,0,0,1,4);
        add(1,0,0,0,1, 1,1,5,0,0,1,1,4);
        add(1,0,0,0,1, 1,1,5,1,1,1,1,4);
        add(1,0,0,0,1, 1,0,0,0,0,0,1,5);
        // Full buffer: offer a third word across a last-beat pop
        add(1,1,6,2,0, 1,0,0,0,0,0,1,5);
        add(1,1,7,2,0, 1,1,6,0,0,1,1,5);
        add(1,1,8,1,1, 0,1,6,0,0,1,1,5);
        add(1,1,8,1,1, 0,1,6,1,1,1,1,5);
        add(1,1,8,1,1, 1,1,7,0,0,1,1,6);
        add(1,0,0,0,1, 0,1,7,1,1,1,1,6);
        add(1,0,0,0,0, 1,1,8,0,1,1,1,7);
        // Push and last-beat pop together at occupancy 1
        add(1,1,9,3,1, 1,1,8,0,1,1,1,7);
        add(1,0,0,0,1, 1,1,9,0,0,1,1,8);
        add(1,0,0,0,1, 1,1,9,1,0,1,1,8);
        add(1,0,0,0,1, 1,1,9,2,1,1,1,8);
        add(1,0,0,0,1, 1,0,0,0,0,0,1,9);
        // Reset on beat 2 of a len-5 burst with the second slot full
        add(1,1,10,5,1, 1,0,0,0,0,0,1,9);
        add(1,1,11,3,1, 1,1,10,0,0,1,1,9);
        add(1,0,0,0,1,  0,1,10,1,0,1,1,9);
        add(0,0,0,0,1,  0,1,10,2,0,1,1,9);
        add(1,0,0,0,1,  0,0,0,0,0,0,0,0);
        add(1,0,0,0,1,  1,0,0,0,0,0,0,0);
        add(1,0,0,0,1,  1,0,0,0,0,0,0,0);
        add(1,1,12,1,1, 1,0,0,0,0,0,0,0);
        add(1,0,0,0,1,  1,1,12,0,1,1,0,0);
        add(1,0,0,0,1,  1,0,0,0,0,0,0,1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("seq_after_reset", -1, seq, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            par_valid   = vecs[i].pv;
            par         = mk_par(vecs[i].tag);
            par_len     = LEN_W'(vecs[i].len);
            app_wdf_rdy = vecs[i].rdy;
            #1;
            $display("vec %0d rst_n=%0b pv=%0b len=%0d rdy=%0b -> pr=%0b sv=%0b seq=%0h last=%0b busy=%0b err=%0b bcnt=%0d",
                     i, rst_n, par_valid, par_len, app_wdf_rdy, par_ready, seq_valid, seq,
                     seq_last, busy, err_len, burst_cnt);
            chk("par_ready", i, W'(par_ready), W'(vecs[i].pr));
            chk("seq_valid", i, W'(seq_valid), W'(vecs[i].sv));
            if (vecs[i].sv) begin
                chk("seq",      i, seq,           bv(vecs[i].etag, vecs[i].ek));
                chk("seq_last", i, W'(seq_last),  W'(vecs[i].sl));
            end else begin
                chk("seq_last", i, W'(seq_last),  '0);
            end
            chk("busy",      i, W'(busy),      W'(vecs[i].busy));
            chk("err_len",   i, W'(err_len),   W'(vecs[i].err));
            chk("burst_cnt", i, W'(burst_cnt), W'(vecs[i].bcnt));
        end

        // Stream 65534 len-1 words: burst_cnt goes 1 -> 0xFFFF, then one more wraps to 0
        @(negedge clk);
        par         = mk_par(13);
        par_len     = LEN_W'(1);
        app_wdf_rdy = 1'b1;
        par_valid   = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        par_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("stream 65534 len-1 words -> bcnt=%0h busy=%0b", burst_cnt, busy);
        chk("burst_cnt_ffff", -2, W'(burst_cnt), W'(16'hFFFF));
        chk("busy_after_stream", -2, W'(busy), '0);

        @(negedge clk);
        par_valid = 1'b1;
        @(negedge clk);
        par_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("one more len-1 word -> bcnt=%0h", burst_cnt);
        chk("burst_cnt_wrap", -3, W'(burst_cnt), '0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
